// File: rtl/pc_redirect_unit.sv
// Fetch-side PC register: sequential fetch with valid/ready handshake, branch/jump
// redirect with a timed flush window, pc+4 link value and sticky misalignment flag.
module pc_redirect_unit #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_PC     = '0,
    parameter int                 FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             taken,
    input  logic             jump,
    input  logic [WIDTH-1:0] target,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             flush,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic             err_q, err_d;

    logic             active;
    logic             redirect_req;
    logic             aligned;
    logic             redir;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through this block can leave a value unassigned and infer a latch.
        active       = (state_q != S_BOOT);
        redirect_req = taken | jump;
        aligned      = (target[1:0] == 2'b00);
        redir        = active & redirect_req & aligned;
        pc_plus4     = pc_q + WIDTH'(4);

        pc_d    = pc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        err_d   = err_q | (active & redirect_req & ~aligned);

        // Redirect wins over stall and handshake; the fetch address otherwise
        // only advances once memory has accepted it.
        if (redir) begin
            pc_d = target;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (active && imem_ready) begin
            pc_d = pc_plus4;
        end

        // Counter keeps draining through stalls; a redirect reloads it so
        // back-to-back redirects give an unbroken flush window.
        if (redir) begin
            cnt_d = FLUSH_LOAD;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
        flush_d = (cnt_d != 3'd0);

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (redir) state_d = S_FLUSH;
            S_FLUSH: if (!redir && cnt_d == 3'd0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = (state_q != S_BOOT);
    assign flush        = flush_q;
    assign misalign_err = err_q;

endmodule
